// File: rtl/front_panel_ctrl_pkg.sv
// Shared front-panel types: machine word and
// panel FSM state encoding.
package CPU_Definitions;

  typedef logic [11:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    DEPOSIT = 2'd3
  } panel_state_t;

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchronizer, stability
// counter and a one-cycle pulse on accepted 0->1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // count consecutive samples that disagree with the held level
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_press <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/front_panel_ctrl.sv
// Front panel controller: debounced buttons drive
// load, deposit, step and run control of the CPU.
module front_panel_ctrl
  import CPU_Definitions::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btnc,
  input  logic         btnu,
  input  logic         btnd,
  input  logic         btnl,
  input  logic         btnr,
  input  logic [12:0]  sw,
  input  logic         cpu_instr_done,
  input  logic         cpu_halted,
  input  logic         dep_ack,
  output logic         cpu_run,
  output logic         load_pc,
  output logic         load_ac,
  output word_t        load_data,
  output logic         dep_req,
  output word_t        dep_addr,
  output word_t        dep_data,
  output logic         disp_sel,
  output panel_state_t panel_state
);

  logic [4:0] w_raw;
  logic [4:0] w_ev;

  assign w_raw = {btnc, btnu, btnd, btnl, btnr};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (w_raw[g]),
      .o_press(w_ev[g])
    );
  end

  logic w_ev_c;
  logic w_ev_u;
  logic w_ev_d;
  logic w_ev_l;
  logic w_ev_r;

  assign {w_ev_c, w_ev_u, w_ev_d, w_ev_l, w_ev_r} = w_ev;

  panel_state_t r_state;
  logic         r_run_s1;
  logic         r_run_s2;
  logic         r_halt;
  logic         r_cpu_run;
  logic         r_load_pc;
  logic         r_load_ac;
  word_t        r_load_data;
  logic         r_dep_req;
  word_t        r_dep_addr;
  word_t        r_dep_data;
  logic         r_disp_sel;
  word_t        r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_halt      <= 1'b0;
      r_cpu_run   <= 1'b0;
      r_load_pc   <= 1'b0;
      r_load_ac   <= 1'b0;
      r_load_data <= '0;
      r_dep_req   <= 1'b0;
      r_dep_addr  <= '0;
      r_dep_data  <= '0;
      r_disp_sel  <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_run_s1  <= sw[12];
      r_run_s2  <= r_run_s1;
      r_load_pc <= 1'b0;
      r_load_ac <= 1'b0;
      if (cpu_halted)
        r_halt <= 1'b1;
      else if (!r_run_s2)
        r_halt <= 1'b0;
      if (w_ev_c)
        r_disp_sel <= ~r_disp_sel;
      unique case (r_state)
        IDLE: begin
          if (w_ev_l) begin
            r_load_pc   <= 1'b1;
            r_load_data <= sw[11:0];
            r_ptr       <= sw[11:0];
          end else if (w_ev_r) begin
            r_load_ac   <= 1'b1;
            r_load_data <= sw[11:0];
          end else if (w_ev_d) begin
            r_state    <= DEPOSIT;
            r_dep_req  <= 1'b1;
            r_dep_addr <= r_ptr;
            r_dep_data <= sw[11:0];
          end else if (w_ev_u) begin
            r_state   <= STEP;
            r_cpu_run <= 1'b1;
          end else if (r_run_s2 && !r_halt) begin
            r_state   <= RUN;
            r_cpu_run <= 1'b1;
          end
        end
        RUN: begin
          if (cpu_halted ||
              (cpu_instr_done && !r_run_s2)) begin
            r_state   <= IDLE;
            r_cpu_run <= 1'b0;
          end
        end
        STEP: begin
          if (cpu_instr_done || cpu_halted) begin
            r_state   <= IDLE;
            r_cpu_run <= 1'b0;
          end
        end
        DEPOSIT: begin
          if (dep_ack) begin
            r_state   <= IDLE;
            r_dep_req <= 1'b0;
            r_ptr     <= r_ptr + 12'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_run     = r_cpu_run;
  assign load_pc     = r_load_pc;
  assign load_ac     = r_load_ac;
  assign load_data   = r_load_data;
  assign dep_req     = r_dep_req;
  assign dep_addr    = r_dep_addr;
  assign dep_data    = r_dep_data;
  assign disp_sel    = r_disp_sel;
  assign panel_state = r_state;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed bench for front_panel_ctrl with a
// short debounce window.
module tb_front_panel_ctrl;
  import CPU_Definitions::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   btn = '0;
  logic [12:0]  sw = '0;
  logic         done = 1'b0;
  logic         halted = 1'b0;
  logic         ack = 1'b0;
  logic         cpu_run;
  logic         load_pc;
  logic         load_ac;
  word_t        load_data;
  logic         dep_req;
  word_t        dep_addr;
  word_t        dep_data;
  logic         disp_sel;
  panel_state_t st;

  int checks = 0;
  int errors = 0;
  int n_lpc = 0;
  int n_lac = 0;
  int n_dep = 0;
  word_t lpc_data = '0;
  word_t lac_data = '0;

  localparam int C = 4, U = 3, D = 2, L = 1, R = 0;

  front_panel_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .btnc          (btn[C]),
    .btnu          (btn[U]),
    .btnd          (btn[D]),
    .btnl          (btn[L]),
    .btnr          (btn[R]),
    .sw            (sw),
    .cpu_instr_done(done),
    .cpu_halted    (halted),
    .dep_ack       (ack),
    .cpu_run       (cpu_run),
    .load_pc       (load_pc),
    .load_ac       (load_ac),
    .load_data     (load_data),
    .dep_req       (dep_req),
    .dep_addr      (dep_addr),
    .dep_data      (dep_data),
    .disp_sel      (disp_sel),
    .panel_state   (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_pc) begin
      n_lpc    <= n_lpc + 1;
      lpc_data <= load_data;
    end
    if (load_ac) begin
      n_lac    <= n_lac + 1;
      lac_data <= load_data;
    end
    if (dep_req) n_dep <= n_dep + 1;
  end

  task automatic hold(input int idx, input int n);
    btn[idx] = 1'b1;
    repeat (n) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_deposit(input word_t d,
                            input word_t ea,
                            input string nm);
    int k;
    sw[11:0] = d;
    btn[D] = 1'b1;
    k = 0;
    while (!dep_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (dep_req !== 1'b1) begin
      errors++;
      $display("FAIL %s dep_req timeout", nm);
    end
    sw[11:0] = ~d;
    repeat (2) @(negedge clk);
    checks++;
    if (dep_addr !== ea || dep_data !== d) begin
      errors++;
      $display("FAIL %s write got %o/%o want %o/%o",
               nm, dep_addr, dep_data, ea, d);
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (dep_req !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL %s after ack req=%b st=%0d want 0/0",
               nm, dep_req, st);
    end
    btn[D] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_run, load_pc, load_ac, dep_req, disp_sel}
        !== 5'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL reset_ctl got %b st=%0d want 0",
               {cpu_run, load_pc, load_ac, dep_req,
                disp_sel}, st);
    end
    checks++;
    if (load_data !== 12'd0 || dep_addr !== 12'd0 ||
        dep_data !== 12'd0) begin
      errors++;
      $display("FAIL reset_data got %o %o %o want 0",
               load_data, dep_addr, dep_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_pc;
    int n0;
    n0 = n_lpc;
    sw = 13'o0200;
    hold(L, 10);
    checks++;
    if (n_lpc - n0 !== 1) begin
      errors++;
      $display("FAIL load_pc_count got %0d want 1",
               n_lpc - n0);
    end
    checks++;
    if (lpc_data !== 12'o0200) begin
      errors++;
      $display("FAIL load_pc_data got %o want 0200",
               lpc_data);
    end
  endtask

  task automatic test_deposit;
    sw = 13'o7777;
    hold(L, 8);
    do_deposit(12'o1234, 12'o7777, "dep1");
    do_deposit(12'o4321, 12'o0000, "dep2");
  endtask

  task automatic test_load_ac;
    int n0, a0;
    n0 = n_lpc;
    a0 = n_lac;
    sw = 13'h123;
    hold(R, 8);
    checks++;
    if (n_lac - a0 !== 1 || lac_data !== 12'h123 ||
        n_lpc !== n0) begin
      errors++;
      $display("FAIL load_ac got n=%0d d=%h pc=%0d",
               n_lac - a0, lac_data, n_lpc - n0);
    end
    do_deposit(12'o0000, 12'o0001, "dep_ptr");
  endtask

  task automatic test_simultaneous;
    int n0, d0;
    n0 = n_lpc;
    d0 = n_dep;
    sw = 13'o0055;
    btn[L] = 1'b1;
    btn[D] = 1'b1;
    repeat (10) @(negedge clk);
    btn[L] = 1'b0;
    btn[D] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (n_lpc - n0 !== 1 || n_dep !== d0) begin
      errors++;
      $display("FAIL simul got lpc=%0d dep=%0d want 1/0",
               n_lpc - n0, n_dep - d0);
    end
  endtask

  task automatic test_run;
    int k;
    logic d0;
    sw = 13'h1000;
    k = 0;
    while (!cpu_run && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cpu_run !== 1'b1 || st !== RUN) begin
      errors++;
      $display("FAIL run_enter run=%b st=%0d want 1/1",
               cpu_run, st);
    end
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL halt run=%b st=%0d want 0/0",
               cpu_run, st);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (st !== IDLE) begin
      errors++;
      $display("FAIL halt_latch st=%0d want 0", st);
    end
    sw = 13'h0000;
    repeat (5) @(negedge clk);
    sw = 13'h1000;
    repeat (5) @(negedge clk);
    checks++;
    if (st !== RUN || cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL rerun st=%0d run=%b want 1/1",
               st, cpu_run);
    end
    d0 = disp_sel;
    hold(C, 8);
    checks++;
    if (disp_sel !== ~d0 || st !== RUN) begin
      errors++;
      $display("FAIL disp_sel got %b st=%0d want %b/1",
               disp_sel, st, ~d0);
    end
    sw = 13'h0000;
    repeat (5) @(negedge clk);
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL run_mid_instr got %b want 1",
               cpu_run);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL run_exit run=%b st=%0d want 0/0",
               cpu_run, st);
    end
  endtask

  task automatic test_step;
    int k, drops, n0;
    n0 = n_lpc;
    btn[U] = 1'b1;
    k = 0;
    while (!cpu_run && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cpu_run !== 1'b1 || st !== STEP) begin
      errors++;
      $display("FAIL step_enter run=%b st=%0d want 1/2",
               cpu_run, st);
    end
    btn[L] = 1'b1;
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_run !== 1'b1) drops++;
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL step_hold drops=%0d want 0", drops);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL step_end run=%b st=%0d want 0/0",
               cpu_run, st);
    end
    repeat (4) @(negedge clk);
    btn[U] = 1'b0;
    btn[L] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (n_lpc !== n0 || st !== IDLE) begin
      errors++;
      $display("FAIL step_ignore lpc=%0d st=%0d want 0/0",
               n_lpc - n0, st);
    end
  endtask

  task automatic test_step_halt;
    int k;
    btn[U] = 1'b1;
    k = 0;
    while (!cpu_run && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL step_halt run=%b st=%0d want 0/0",
               cpu_run, st);
    end
    btn[U] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_deposit;
    int k;
    sw = 13'o0033;
    btn[D] = 1'b1;
    k = 0;
    while (!dep_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (dep_req !== 1'b1 || st !== DEPOSIT) begin
      errors++;
      $display("FAIL rstdep_enter req=%b st=%0d want 1/3",
               dep_req, st);
    end
    reset = 1'b1;
    btn[D] = 1'b0;
    #1;
    checks++;
    if (dep_req !== 1'b0 || st !== IDLE ||
        dep_addr !== 12'd0) begin
      errors++;
      $display("FAIL rstdep req=%b st=%0d a=%o want 0/0/0",
               dep_req, st, dep_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    do_deposit(12'o0011, 12'o0000, "dep_after_rst");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_pc();
    test_deposit();
    test_load_ac();
    test_simultaneous();
    test_run();
    test_step();
    test_step_halt();
    test_reset_deposit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
